// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode / write-back side bundle for the scoreboarded register file.
//   master : decode + write-back (drives addresses, write data/mode, busy-set)
//   slave  : register file (returns read data, hazard flags, busy count)
//   A1/A2 -> RD1/RD2, rs1_busy/rs2_busy ; A3/WD3/WE3 write-back ;
//   busy_set/busy_addr mark a pending load ; busy_cnt = registers pending.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic [2:0]      WE3;
  logic            busy_set;
  logic [AW-1:0]   busy_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW:0]     busy_cnt;

  modport master (
    output A1, A2, A3, WD3, WE3, busy_set, busy_addr,
    input  RD1, RD2, rs1_busy, rs2_busy, busy_cnt
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, busy_set, busy_addr,
    output RD1, RD2, rs1_busy, rs2_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x XLEN integer register file, 2 combinational read ports,
// 1 write-back port with load-width extension, write-to-read bypass and a
// per-register busy scoreboard for multi-cycle loads.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (clears array, busy bits, count)
//   bus  : regfile_sb_if.slave (read/write/scoreboard signals)

// One read port: x0 forcing, bypass from the current write, hazard flag.
module regfile_sb_rport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                        rst,
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic                        wr_vld,
  input  logic [AW-1:0]               wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  output logic [XLEN-1:0]             rd,
  output logic                        rs_busy
);
  logic hit;

  // wr_vld already excludes A3 == 0, so a hit never targets x0
  assign hit = wr_vld && (wr_addr == addr);

  always_comb begin
    rd      = '0;
    rs_busy = 1'b0;
    if (!rst && addr != '0) begin
      rd      = hit ? wr_data : regs[addr];
      // a completing write-back resolves the hazard through the bypass
      rs_busy = busy[addr] && !hit;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_nxt;
  logic [XLEN-1:0]            ext;
  logic                       wr_vld;

  logic [1:0][AW-1:0]   ra;
  logic [1:0][XLEN-1:0] rd;
  logic [1:0]           rs_busy;

  // write-data extension by load width
  always_comb begin
    ext = '0;
    case (bus.WE3)
      3'b001:  ext = bus.WD3;
      3'b010:  ext = {{(XLEN-8){bus.WD3[7]}},   bus.WD3[7:0]};
      3'b011:  ext = {{(XLEN-16){bus.WD3[15]}}, bus.WD3[15:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},         bus.WD3[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}},        bus.WD3[15:0]};
      default: ext = '0;
    endcase
  end

  // 000 and reserved 110/111 are no-ops; x0 is never written
  assign wr_vld = (bus.WE3 >= 3'd1) && (bus.WE3 <= 3'd5) && (bus.A3 != '0);

  // scoreboard next state: clear on write-back, then set (set wins on same reg)
  always_comb begin
    busy_nxt = busy;
    if (wr_vld) busy_nxt[bus.A3] = 1'b0;
    if (bus.busy_set && bus.busy_addr != '0) busy_nxt[bus.busy_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 1; i < NREGS; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs  <= '0;
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_vld) regs[bus.A3] <= ext;
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign ra[0] = bus.A1;
  assign ra[1] = bus.A2;

  for (genvar g = 0; g < 2; g++) begin : g_rport
    regfile_sb_rport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rport (
      .rst     (rst),
      .addr    (ra[g]),
      .regs    (regs),
      .busy    (busy),
      .wr_vld  (wr_vld),
      .wr_addr (bus.A3),
      .wr_data (ext),
      .rd      (rd[g]),
      .rs_busy (rs_busy[g])
    );
  end

  assign bus.RD1      = rd[0];
  assign bus.RD2      = rd[1];
  assign bus.rs1_busy = rs_busy[0];
  assign bus.rs2_busy = rs_busy[1];
  // count is registered; forced to 0 while reset is asserted
  assign bus.busy_cnt = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic for regfile_sb,
// checked against an array-based model of register and busy state.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mr [NREGS];
  bit          mb [NREGS];

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] m_ext(input logic [2:0] m, input logic [31:0] d);
    int b, h;
    b = int'(d & 32'hFF);
    h = int'(d & 32'hFFFF);
    case (m)
      3'd1: return d;
      3'd2: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd3: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_wr();
    return (bus.WE3 >= 1) && (bus.WE3 <= 5) && (bus.A3 != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (rst || a == 0) return 32'h0;
    if (m_wr() && int'(bus.A3) == a) return m_ext(bus.WE3, bus.WD3);
    return mr[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (rst || a == 0) return 1'b0;
    return mb[a] && !(m_wr() && int'(bus.A3) == a);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    if (rst) return 0;
    foreach (mb[i]) c += int'(mb[i]);
    return c;
  endfunction

  task automatic drive(input int a1, input int a2, input int a3, input logic [31:0] wd,
                       input int we, input bit bs, input int ba);
    bus.A1 = 5'(a1); bus.A2 = 5'(a2); bus.A3 = 5'(a3); bus.WD3 = wd;
    bus.WE3 = 3'(we); bus.busy_set = bs; bus.busy_addr = 5'(ba);
  endtask

  // rising edge, then apply the same inputs to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (mr[i]) begin mr[i] = 0; mb[i] = 0; end
    end else begin
      if (m_wr()) begin
        mr[bus.A3] = m_ext(bus.WE3, bus.WD3);
        mb[bus.A3] = 0;
      end
      if (bus.busy_set && bus.busy_addr != 0) mb[bus.busy_addr] = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3, 4, 3, 32'hFFFF_FFFF, 1, 1'b1, 3);
    #1;
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL reset_rd1: got %h want 0", bus.RD1); end
    n_checks++; if (bus.RD2 !== 32'h0) begin n_errors++; $display("FAIL reset_rd2: got %h want 0", bus.RD2); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_errors++; $display("FAIL reset_rs1: got %b want 0", bus.rs1_busy); end
    tick();
    tick();
    n_checks++; if (bus.busy_cnt !== 6'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", bus.busy_cnt); end
    rst = 1'b0;
    drive(3, 4, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL reset_clear_rd1: got %h want 0", bus.RD1); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_errors++; $display("FAIL reset_clear_rs1: got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_write_read();
    drive(0, 0, 5, 32'h1234_5678, 1, 1'b0, 0);
    tick();
    drive(5, 0, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.RD1 !== 32'h1234_5678) begin n_errors++; $display("FAIL write_read: got %h want 12345678", bus.RD1); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL rst_held_rd1: got %h want 0", bus.RD1); end
    n_checks++; if (bus.busy_cnt !== 6'd0) begin n_errors++; $display("FAIL rst_held_cnt: got %0d want 0", bus.busy_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    logic [31:0] wd [4] = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_8001, 32'h0000_8001};
    int          we [4] = '{2, 4, 3, 5};
    logic [31:0] ex [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      drive(0, 7, 7, wd[i], we[i], 1'b0, 0);
      #1;
      n_checks++; if (bus.RD2 !== ex[i]) begin n_errors++; $display("FAIL bypass_we%0d: got %h want %h", we[i], bus.RD2, ex[i]); end
      tick();
    end
    drive(0, 7, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.RD2 !== 32'h0000_8001) begin n_errors++; $display("FAIL bypass_commit: got %h want 00008001", bus.RD2); end
  endtask

  task automatic test_x0();
    drive(0, 0, 0, 32'hDEAD_BEEF, 1, 1'b1, 0);
    #1;
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL x0_rd1: got %h want 0", bus.RD1); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_errors++; $display("FAIL x0_rs1: got %b want 0", bus.rs1_busy); end
    tick();
    drive(0, 0, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.busy_cnt !== 6'd0) begin n_errors++; $display("FAIL x0_cnt: got %0d want 0", bus.busy_cnt); end
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL x0_rd1_after: got %h want 0", bus.RD1); end
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 1'b1, 9);
    tick();
    drive(9, 0, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_errors++; $display("FAIL sb_set_rs1: got %b want 1", bus.rs1_busy); end
    n_checks++; if (bus.busy_cnt !== 6'd1) begin n_errors++; $display("FAIL sb_set_cnt: got %0d want 1", bus.busy_cnt); end
    drive(9, 9, 9, 32'hAB, 1, 1'b0, 0);
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_errors++; $display("FAIL sb_wb_rs1: got %b want 0", bus.rs1_busy); end
    n_checks++; if (bus.RD1 !== 32'hAB) begin n_errors++; $display("FAIL sb_wb_rd1: got %h want ab", bus.RD1); end
    tick();
    drive(9, 0, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.busy_cnt !== 6'd0) begin n_errors++; $display("FAIL sb_clear_cnt: got %0d want 0", bus.busy_cnt); end
  endtask

  task automatic test_set_clear();
    drive(0, 0, 0, 0, 0, 1'b1, 3);
    tick();
    drive(0, 0, 0, 0, 0, 1'b1, 12);
    tick();
    drive(0, 0, 3, 32'h5A5A_0003, 1, 1'b1, 3);
    tick();
    drive(3, 12, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_errors++; $display("FAIL setclr_rs1: got %b want 1", bus.rs1_busy); end
    n_checks++; if (bus.rs2_busy !== 1'b1) begin n_errors++; $display("FAIL setclr_rs2: got %b want 1", bus.rs2_busy); end
    n_checks++; if (bus.busy_cnt !== 6'd2) begin n_errors++; $display("FAIL setclr_cnt: got %0d want 2", bus.busy_cnt); end
    n_checks++; if (bus.RD1 !== 32'h5A5A_0003) begin n_errors++; $display("FAIL setclr_rd1: got %h want 5a5a0003", bus.RD1); end
    drive(0, 0, 12, 32'h1, 1, 1'b1, 12);
    tick();
    drive(0, 0, 0, 0, 0, 1'b1, 12);
    tick();
    drive(12, 0, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.busy_cnt !== 6'd2) begin n_errors++; $display("FAIL reset_busy_cnt: got %0d want 2", bus.busy_cnt); end
  endtask

  task automatic test_reserved_reset();
    drive(0, 0, 4, 32'h44, 1, 1'b1, 4);
    tick();
    drive(4, 0, 4, 32'h9999_9999, 6, 1'b0, 0);
    #1;
    n_checks++; if (bus.RD1 !== 32'h44) begin n_errors++; $display("FAIL rsv_bypass: got %h want 44", bus.RD1); end
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_errors++; $display("FAIL rsv_rs1: got %b want 1", bus.rs1_busy); end
    tick();
    drive(4, 0, 4, 32'h7777_7777, 7, 1'b0, 0);
    tick();
    #1;
    n_checks++; if (bus.RD1 !== 32'h44) begin n_errors++; $display("FAIL rsv_keep: got %h want 44", bus.RD1); end
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_errors++; $display("FAIL rsv_busy: got %b want 1", bus.rs1_busy); end
    rst = 1'b1;
    drive(4, 3, 4, 32'h1234, 1, 1'b1, 6);
    tick();
    rst = 1'b0;
    drive(4, 3, 0, 0, 0, 1'b0, 0);
    #1;
    n_checks++; if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL rstdom_rd1: got %h want 0", bus.RD1); end
    n_checks++; if (bus.RD2 !== 32'h0) begin n_errors++; $display("FAIL rstdom_rd2: got %h want 0", bus.RD2); end
    n_checks++; if (bus.busy_cnt !== 6'd0) begin n_errors++; $display("FAIL rstdom_cnt: got %0d want 0", bus.busy_cnt); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_errors++; $display("FAIL rstdom_rs1: got %b want 0", bus.rs1_busy); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    bit          b1, b2;
    int          ec;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.A1 = 5'($urandom_range(0, NREGS - 1));
      #1;
      e1 = exp_rd(int'(bus.A1)); e2 = exp_rd(int'(bus.A2));
      b1 = exp_busy(int'(bus.A1)); b2 = exp_busy(int'(bus.A2)); ec = exp_cnt();
      n_checks++; if (bus.RD1 !== e1) begin n_errors++; $display("FAIL rnd_rd1 @%0d: got %h want %h", n, bus.RD1, e1); end
      n_checks++; if (bus.RD2 !== e2) begin n_errors++; $display("FAIL rnd_rd2 @%0d: got %h want %h", n, bus.RD2, e2); end
      n_checks++; if (bus.rs1_busy !== b1) begin n_errors++; $display("FAIL rnd_rs1 @%0d: got %b want %b", n, bus.rs1_busy, b1); end
      n_checks++; if (bus.rs2_busy !== b2) begin n_errors++; $display("FAIL rnd_rs2 @%0d: got %b want %b", n, bus.rs2_busy, b2); end
      n_checks++; if (int'(bus.busy_cnt) != ec) begin n_errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, bus.busy_cnt, ec); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    foreach (mr[i]) begin mr[i] = 0; mb[i] = 0; end
    drive(0, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_set_clear();
    test_reserved_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
